// File: rtl/send_buffers_if.sv
// rtl/send_buffers_if.sv - pixel load, command and replay signals of send_buffers
interface send_buffers_if #(
  parameter int BUFF_SIZE_BIT = 6
);
  logic [7:0]               ld_px;
  logic                     ld_px_empty;
  logic                     ld_px_rd;
  logic [BUFF_SIZE_BIT-1:0] ld_size;
  logic                     cmd_valid;
  logic [1:0]               cmd_sel;
  logic [7:0]               pivot;
  logic                     cmd_ready;
  logic [7:0]               out_px;
  logic                     out_px_full;
  logic                     out_px_wr;
  logic                     sending;
  logic [BUFF_SIZE_BIT-1:0] sent_count;
  logic [BUFF_SIZE_BIT-1:0] win_size;
  logic                     send_done;

  modport slave (
    input  ld_px, ld_px_empty, ld_size, cmd_valid, cmd_sel, pivot, out_px_full,
    output ld_px_rd, cmd_ready, out_px, out_px_wr, sending, sent_count, win_size, send_done
  );

  modport master (
    output ld_px, ld_px_empty, ld_size, cmd_valid, cmd_sel, pivot, out_px_full,
    input  ld_px_rd, cmd_ready, out_px, out_px_wr, sending, sent_count, win_size, send_done
  );
endinterface

// File: rtl/send_buffers.sv
// rtl/send_buffers.sv - window capture and filtered replay into the downstream pixel FIFO
module send_buffers #(
  parameter int BUFF_SIZE     = 32,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  send_buffers_if.slave    bus
);
  localparam int AW = (BUFF_SIZE > 1) ? $clog2(BUFF_SIZE) : 1;
  localparam logic [BUFF_SIZE_BIT-1:0] MAX_SIZE = BUFF_SIZE_BIT'(BUFF_SIZE);

  typedef enum logic [2:0] {IDLE, LOAD, READY, SEND, DONE} state_t;

  state_t                   state;
  logic [7:0]               mem [BUFF_SIZE];
  logic [BUFF_SIZE_BIT-1:0] wptr;
  logic [BUFF_SIZE_BIT-1:0] wptr_next;
  logic [BUFF_SIZE_BIT-1:0] idx;
  logic [BUFF_SIZE_BIT-1:0] win_size_q;
  logic [BUFF_SIZE_BIT-1:0] sent_count_q;
  logic [1:0]               sel_q;
  logic [7:0]               pivot_q;
  logic [7:0]               cur;
  logic                     match;
  logic                     accept;
  logic                     consume;
  logic                     stall;

  assign cur       = mem[idx[AW-1:0]];
  assign wptr_next = wptr + 1'b1;
  assign accept    = bus.cmd_valid && bus.cmd_ready;
  assign consume   = bus.ld_px_rd && !bus.ld_px_empty;
  assign stall     = match && bus.out_px_full;

  always_comb begin
    match = 1'b0;
    case (sel_q)
      2'b00:   match = 1'b1;
      2'b01:   match = (cur < pivot_q);
      2'b10:   match = (cur > pivot_q);
      default: match = 1'b0;
    endcase
    // An empty window must never produce a write from stale memory.
    if (win_size_q == '0) match = 1'b0;
  end

  assign bus.ld_px_rd   = (state == LOAD) && (wptr != win_size_q);
  assign bus.cmd_ready  = (state == IDLE) || (state == READY);
  assign bus.sending    = (state == SEND);
  assign bus.out_px     = (state == SEND) ? cur : 8'd0;
  assign bus.out_px_wr  = (state == SEND) && match && !bus.out_px_full;
  assign bus.send_done  = (state == DONE);
  assign bus.sent_count = sent_count_q;
  assign bus.win_size   = win_size_q;

  always_ff @(posedge clk) begin
    if (consume) mem[wptr[AW-1:0]] <= bus.ld_px;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wptr         <= '0;
      idx          <= '0;
      win_size_q   <= '0;
      sent_count_q <= '0;
      sel_q        <= 2'b00;
      pivot_q      <= 8'd0;
    end else if (accept && bus.cmd_sel == 2'b11) begin
      win_size_q <= (bus.ld_size > MAX_SIZE) ? MAX_SIZE : bus.ld_size;
      wptr       <= '0;
      state      <= LOAD;
    end else begin
      case (state)
        IDLE: state <= IDLE;
        LOAD: begin
          if (consume) begin
            wptr <= wptr_next;
            if (wptr_next == win_size_q) state <= READY;
          end else if (wptr == win_size_q) begin
            state <= READY;
          end
        end
        READY: begin
          if (accept) begin
            sel_q        <= bus.cmd_sel;
            pivot_q      <= bus.pivot;
            sent_count_q <= '0;
            idx          <= '0;
            state        <= SEND;
          end
        end
        SEND: begin
          if (win_size_q == '0) begin
            state <= DONE;
          end else if (!stall) begin
            idx <= idx + 1'b1;
            if (match) sent_count_q <= sent_count_q + 1'b1;
            if (idx == win_size_q - 1'b1) state <= DONE;
          end
        end
        DONE:    state <= READY;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_send_buffers.sv
// tb/tb_send_buffers.sv - directed self-checking bench for send_buffers with a queue-based model
module tb_send_buffers;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  send_buffers_if #(.BUFF_SIZE_BIT(6)) bus ();
  send_buffers #(.BUFF_SIZE(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] src_q [$];
  logic [7:0] win_m [$];
  logic [7:0] exp_q [$];
  int model_sent  = 0;
  int send_cycles = 0;
  int done_pulses = 0;
  int consumed    = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic upd_src();
    bus.ld_px       = (src_q.size() > 0) ? src_q[0] : 8'd0;
    bus.ld_px_empty = (src_q.size() == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upstream FWFT FIFO: pop on each consumed pixel.
  always @(posedge clk) begin
    if (rst_n && bus.ld_px_rd && !bus.ld_px_empty) begin
      void'(src_q.pop_front());
      consumed++;
    end
    #1 upd_src();
  end

  // Cycle-by-cycle compare against the write queue and running count.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("sent_count_track", int'(bus.sent_count), model_sent);
      if (bus.out_px_wr) begin
        chk("wr_only_in_send", int'(bus.sending), 1);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got px %0d expected no write", bus.out_px);
        end else begin
          if (bus.out_px != exp_q[0]) begin
            n_fail++;
            $display("FAIL out_px: got %0d expected %0d", bus.out_px, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        model_sent++;
      end
      if (bus.sending) send_cycles++;
      if (bus.send_done) done_pulses++;
    end
  end

  task automatic set_src(input int npx, input int size, input int mul, input int base);
    int n;
    src_q = {};
    win_m = {};
    n = (size > 32) ? 32 : size;
    for (int i = 0; i < npx; i++) src_q.push_back(8'(base + i * mul));
    for (int i = 0; i < n; i++) win_m.push_back(src_q[i]);
    upd_src();
  endtask

  task automatic set_src5();
    src_q = '{8'd10, 8'd40, 8'd20, 8'd40, 8'd90};
    win_m = src_q;
    upd_src();
  endtask

  task automatic issue(input logic [1:0] sel, input logic [7:0] pv, input int size);
    chk("cmd_ready_before_issue", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = sel;
    bus.pivot     = pv;
    bus.ld_size   = 6'(size);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic load(input int size, input int exp_n, input string tag);
    int k;
    consumed = 0;
    issue(2'b11, 8'd0, size);
    for (k = 0; k < 200; k++) begin
      if (bus.cmd_ready) break;
      tick();
    end
    chk({tag, "_load_in_time"}, int'(k < 200), 1);
    chk({tag, "_consumed"}, consumed, exp_n);
    chk({tag, "_win_size"}, int'(bus.win_size), exp_n);
  endtask

  task automatic send(input logic [1:0] sel, input logic [7:0] pv, input int full_cycles,
                      input int exp_writes, input int exp_len, input string tag);
    int k;
    exp_q = {};
    foreach (win_m[i])
      if (sel == 2'b00 || (sel == 2'b01 && win_m[i] < pv) || (sel == 2'b10 && win_m[i] > pv))
        exp_q.push_back(win_m[i]);
    chk({tag, "_model_count"}, exp_q.size(), exp_writes);
    issue(sel, pv, 0);
    model_sent = 0;
    send_cycles = 0;
    done_pulses = 0;
    bus.out_px_full = (full_cycles > 0);
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      #1;
      if (bus.send_done) break;
      @(posedge clk);
      #1;
      bus.out_px_full = (k + 1 <= full_cycles);
    end
    chk({tag, "_done_latency"}, k, exp_len + 1);
    chk({tag, "_send_len"}, send_cycles, exp_len);
    chk({tag, "_sent_count"}, int'(bus.sent_count), exp_writes);
    chk({tag, "_all_written"}, exp_q.size(), 0);
    bus.out_px_full = 1'b0;
    tick();
    chk({tag, "_done_pulses"}, done_pulses, 1);
    chk({tag, "_ready_after"}, int'(bus.cmd_ready), 1);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_sel = 2'b00;
    bus.pivot = 8'd0;
    bus.ld_size = 6'd0;
    bus.out_px_full = 1'b0;
    upd_src();
    #3;
    chk("rst_ld_px_rd", int'(bus.ld_px_rd), 0);
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_out_px", int'(bus.out_px), 0);
    chk("rst_out_px_wr", int'(bus.out_px_wr), 0);
    chk("rst_sending", int'(bus.sending), 0);
    chk("rst_sent_count", int'(bus.sent_count), 0);
    chk("rst_win_size", int'(bus.win_size), 0);
    chk("rst_send_done", int'(bus.send_done), 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Non-load command in IDLE is ignored.
    done_pulses = 0;
    issue(2'b00, 8'd0, 0);
    tick();
    chk("idle_ignore_ready", int'(bus.cmd_ready), 1);
    chk("idle_ignore_sending", int'(bus.sending), 0);
    chk("idle_ignore_done", done_pulses, 0);

    set_src5();
    load(5, 5, "t1");
    send(2'b00, 8'd0, 0, 5, 5, "t1_all");
    send(2'b01, 8'd40, 0, 2, 5, "t2_lower");
    send(2'b10, 8'd40, 7, 1, 8, "t3_larger_stall");

    set_src(1, 0, 1, 7);
    load(0, 0, "t4");
    chk("t4_pixel_left", src_q.size(), 1);
    send(2'b00, 8'd0, 0, 0, 1, "t4_empty");

    set_src(40, 40, 3, 0);
    load(40, 32, "t5");
    chk("t5_src_left", src_q.size(), 8);
    send(2'b10, 8'd50, 0, 15, 32, "t5_larger");
    src_q = {};
    upd_src();

    set_src5();
    load(5, 5, "t6");
    exp_q = win_m;
    issue(2'b00, 8'd0, 0);
    model_sent = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (model_sent == 2) break;
    end
    chk("t6_two_writes_seen", model_sent, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_sending", int'(bus.sending), 0);
    chk("t6_rst_sent_count", int'(bus.sent_count), 0);
    chk("t6_rst_win_size", int'(bus.win_size), 0);
    chk("t6_rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("t6_rst_out_px_wr", int'(bus.out_px_wr), 0);
    model_sent = 0;
    exp_q = {};
    tick();
    rst_n = 1'b1;
    set_src5();
    load(5, 5, "t6b");
    send(2'b01, 8'd40, 0, 2, 5, "t6b_lower");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/send_buffers.md
# send_buffers

Window replay source for the median datapath. Captures a window of up to BUFF_SIZE 8-bit pixels from an upstream FWFT FIFO, then, per command, replays either the whole window or only the pixels strictly below or strictly above a pivot into the downstream pixel FIFO that feeds the partitioning stage. Its `sending` output drives that stage's `sending` input, so a fill pass cannot complete while a replay is in progress.

## Interface
- BUFF_SIZE, 32, maximum window depth in pixels
- BUFF_SIZE_BIT, $clog2(BUFF_SIZE)+1, width of size and count fields
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ld_px  in  8  upstream pixel, valid when ld_px_empty=0
- ld_px_empty  in  1  upstream FIFO empty
- ld_px_rd  out  1  upstream read; a pixel is consumed in a cycle where ld_px_rd=1 and ld_px_empty=0
- ld_size  in  BUFF_SIZE_BIT  window length, sampled on load-command accept
- cmd_valid  in  1  command request
- cmd_sel  in  2  00 replay all, 01 replay lower (px<pivot), 10 replay larger (px>pivot), 11 load new window
- pivot  in  8  compare value, sampled on command accept
- cmd_ready  out  1  command can be accepted
- out_px  out  8  replayed pixel
- out_px_full  in  1  downstream FIFO full
- out_px_wr  out  1  downstream write strobe
- sending  out  1  replay in progress
- sent_count  out  BUFF_SIZE_BIT  pixels written in the current/last replay
- win_size  out  BUFF_SIZE_BIT  pixels held in the current window
- send_done  out  1  one-cycle pulse at end of replay

## Operation
- States: IDLE, LOAD, READY, SEND, DONE. Reset state IDLE.
- Command accept: cmd_valid & cmd_ready. cmd_ready=1 in IDLE and READY only.
- IDLE: cmd_sel=11 -> LOAD; other selections accepted and ignored (remain IDLE, no send_done).
- On load accept: win_size <= min(ld_size, BUFF_SIZE); write pointer cleared.
- LOAD: ld_px_rd=1. Each consumed pixel written to mem[wptr], wptr++. When wptr==win_size -> READY. win_size=0 -> READY on the next cycle with no reads.
- READY: cmd_sel=11 -> LOAD (window discarded); 00/01/10 -> SEND; pivot and selection latched; sent_count <= 0; read index idx <= 0.
- SEND, per cycle, with cur=mem[idx]: match = 1 (sel 00), cur<pivot (01), cur>pivot (10). Pixels equal to pivot never match 01 or 10.
  - match & ~out_px_full: out_px_wr=1, out_px=cur, sent_count++, idx++.
  - match & out_px_full: stall; idx, out_px held; out_px_wr=0.
  - ~match: out_px_wr=0, idx++ (one cycle per skipped pixel).
  - After element win_size-1 advances -> DONE. win_size=0: SEND lasts one cycle, no writes.
- DONE: send_done=1 for one cycle -> READY. Window retained; repeated replays allowed.
- sending=1 exactly in SEND. Comparisons unsigned 8-bit.
- Memory contents need not be reset; all control state and outputs are.

## Timing
- Reset values: ld_px_rd=0, cmd_ready=1, out_px=0, out_px_wr=0, sending=0, sent_count=0, win_size=0, send_done=0.
- out_px_wr, out_px, ld_px_rd, cmd_ready, sending are combinational from state/idx/full; counters and state registered.
- Command accepted in cycle N -> LOAD or SEND in cycle N+1; first write earliest at N+1.
- Replay length = win_size + stall cycles; send_done in the cycle after the last element advances.
- Load length = win_size + upstream-empty cycles.
- rst_n asserted mid-LOAD or mid-SEND: immediate return to IDLE, outputs at reset values, partial window discarded (win_size=0).
- out_px_full changing while no match: no effect.

## Test plan
- Load 5 pixels {10,40,20,40,90}, send 00, full=0 -> writes 10,40,20,40,90 on 5 consecutive cycles; sent_count=5; send_done one cycle later.
- Same window, send 01, pivot 40 -> writes 10,20 only; SEND lasts 5 cycles; sent_count=2.
- Same window, send 10, pivot 40, full held high 3 cycles on first match -> single write of 90 after stall; SEND lasts 8 cycles.
- Load with ld_size=0, then send 00 -> no ld_px_rd consumption, no writes, send_done 2 cycles after accept.
- ld_size=40 with BUFF_SIZE=32 -> exactly 32 pixels consumed, win_size=32.
- rst_n low during SEND after 2 writes -> sending=0, sent_count=0, win_size=0, state IDLE; next load/send behaves normally.
